// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer and the register bank it serves.
package word_serializer_pkg;

  // Word width shared with the 32-bit register bank.
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to hold a count from 0 to max inclusive (at least 1).
  function automatic int cnt_bits(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/word_serializer_bit_counter.sv
// Bit-position counter for the serializer: counts 0..MAX on en, clr wins.
module word_serializer_bit_counter
  import word_serializer_pkg::*;
#(
  parameter int MAX = DEFAULT_WIDTH - 1,
  parameter int CW  = cnt_bits(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_max
);

  assign at_max = (count == CW'(MAX));

  // Count register: clear has priority, and the count returns to 0 explicitly
  // after MAX rather than overflowing through the top of the range.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out word transmitter with valid/ready on both sides.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = cnt_bits(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next, shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             cnt_at_max;
  logic             cnt_clr;
  logic             accept;
  logic             xfer;

  // Handshake terms and frame markers. in_ready depends combinationally on
  // ser_ready so a new word can load on the last-bit transfer with no bubble.
  assign ser_valid = (state == ST_SHIFT);
  assign busy      = (state == ST_SHIFT);
  assign xfer      = ser_valid & ser_ready;
  assign ser_first = ser_valid & (cnt == '0);
  assign ser_last  = ser_valid & cnt_at_max;
  assign in_ready  = (state == ST_IDLE) | (xfer & cnt_at_max);
  assign accept    = in_valid & in_ready;
  assign ser_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // Move the word one place toward the output end, zero-filling behind it,
  // so the register is all zeros once the last bit has gone.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};

  word_serializer_bit_counter #(
    .MAX (WIDTH - 1),
    .CW  (CW)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (xfer),
    .count  (cnt),
    .at_max (cnt_at_max)
  );

  // Next-state and datapath decode: load on accept, shift on each transfer.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_next = in_data;
          cnt_clr    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (cnt_at_max) begin
            cnt_clr = 1'b1;
            if (accept) begin
              shreg_next = in_data;
            end else begin
              shreg_next = shreg_shifted;
              state_next = ST_IDLE;
            end
          end else begin
            shreg_next = shreg_shifted;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and shift register; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share the
// stimulus; a bit-queue model predicts every output each cycle.
module tb_word_serializer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         ser_ready;

  logic in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m;
  logic in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .ser_ready(ser_ready), .ser_first(ser_first_m), .ser_last(ser_last_m),
    .busy(busy_m)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_ready(ser_ready), .ser_first(ser_first_l), .ser_last(ser_last_l),
    .busy(busy_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the bits still to be sent, in transmit order, with
  // each bit's position inside its word.
  bit q_msb[$];
  bit q_lsb[$];
  int q_idx[$];

  // Observations from the most recent step.
  bit            accepted;
  bit            obs_xfer;
  bit            obs_last;
  bit            obs_valid;
  bit            obs_first;
  logic [W-1:0]  cap_m;
  logic [W-1:0]  cap_l;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] msb_stream;  // bit W-1 is the first bit on the wire
    logic [W-1:0] lsb_stream;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, {31'd0, ser_valid_m}, 32'd0);
    check({tag, " busy"},  {31'd0, busy_m},      32'd0);
    check({tag, " ready"}, {31'd0, in_ready_m},  32'd1);
    check({tag, " out"},   {31'd0, ser_out_m},   32'd0);
    check({tag, " first"}, {31'd0, ser_first_m}, 32'd0);
    check({tag, " last"},  {31'd0, ser_last_m},  32'd0);
    check({tag, " valid_l"}, {31'd0, ser_valid_l}, 32'd0);
  endtask

  // One clock: compare every output against the model on the falling edge,
  // advance the model by what the rising edge will do, return #1 after it.
  task automatic step();
    bit ev, eout_m, eout_l, efirst, elast, eready;
    @(negedge clk);
    ev     = (q_msb.size() != 0);
    eout_m = ev ? q_msb[0] : 1'b0;
    eout_l = ev ? q_lsb[0] : 1'b0;
    efirst = ev && (q_idx[0] == 0);
    elast  = ev && (q_idx[0] == W - 1);
    eready = !ev || (elast && ser_ready);

    check("ser_valid",   {31'd0, ser_valid_m}, {31'd0, ev});
    check("busy",        {31'd0, busy_m},      {31'd0, ev});
    check("in_ready",    {31'd0, in_ready_m},  {31'd0, eready});
    check("ser_first",   {31'd0, ser_first_m}, {31'd0, efirst});
    check("ser_last",    {31'd0, ser_last_m},  {31'd0, elast});
    check("ser_out_msb", {31'd0, ser_out_m},   {31'd0, eout_m});
    check("ser_valid_l", {31'd0, ser_valid_l}, {31'd0, ev});
    check("busy_l",      {31'd0, busy_l},      {31'd0, ev});
    check("in_ready_l",  {31'd0, in_ready_l},  {31'd0, eready});
    check("ser_first_l", {31'd0, ser_first_l}, {31'd0, efirst});
    check("ser_last_l",  {31'd0, ser_last_l},  {31'd0, elast});
    check("ser_out_lsb", {31'd0, ser_out_l},   {31'd0, eout_l});

    obs_valid = ser_valid_m;
    obs_first = ser_first_m;
    obs_last  = ser_last_m;
    obs_xfer  = ser_valid_m && ser_ready;
    if (obs_xfer) begin
      cap_m = {cap_m[W-2:0], ser_out_m};
      cap_l = {cap_l[W-2:0], ser_out_l};
    end

    accepted = in_valid && eready && rst_n;
    if (ev && ser_ready) begin
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
      void'(q_idx.pop_front());
    end
    if (accepted) begin
      for (int i = 0; i < W; i++) begin
        q_msb.push_back(in_data[W-1-i]);
        q_lsb.push_back(in_data[i]);
        q_idx.push_back(i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until accepted (bounded).
  task automatic send_word(input logic [W-1:0] w);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 100 && !done; k++) begin
      step();
      done = accepted;
    end
    if (!done) check("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Run until the last bit transfers (bounded); returns cycles used.
  task automatic run_to_last(output int cycles);
    bit done = 0;
    cycles = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      cycles++;
      done = obs_last && obs_xfer;
    end
    if (!done) check("last-bit timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int nvalid;
    int nfirst;
    int nacc;

    vecs[0] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hF0F0_A5A5};
    vecs[1] = '{32'h0000_0003, 32'h0000_0003, 32'hC000_0000};
    vecs[2] = '{32'h1234_5678, 32'h1234_5678, 32'h1E6A_2C48};
    vecs[3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    vecs[4] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'hDEAD_BEEF;
    ser_ready = 1'b1;

    // Reset held for 3 cycles, then idle with in_valid low.
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Table: single words with ser_ready held high, both bit orders.
    foreach (vecs[v]) begin
      cap_m = '0;
      cap_l = '0;
      send_word(vecs[v].word);
      in_data = ~vecs[v].word;  // must not disturb the word in flight
      run_to_last(cyc);
      check("vec msb stream", cap_m, vecs[v].msb_stream);
      check("vec lsb stream", cap_l, vecs[v].lsb_stream);
      check("vec bit count", cyc, W);
      step();
      check("vec idle after", {31'd0, ser_valid_m}, 32'd0);
    end

    // Back-to-back words with in_valid held: 64 valid bits, no gap.
    send_word(32'hFFFF_FFFF);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    nvalid = 0;
    nfirst = 0;
    nacc   = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (obs_valid) nvalid++;
      if (obs_first) nfirst++;
      if (accepted) begin
        nacc++;
        in_valid = 1'b0;
      end
    end
    check("b2b valid bits", nvalid, 2 * W);
    check("b2b first marks", nfirst, 2);
    check("b2b second accept", nacc, 1);
    step();

    // Backpressure: stall 4 cycles while bit 10 is presented.
    cap_m = '0;
    cap_l = '0;
    send_word(32'h1234_5678);
    cyc = 0;
    begin
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        step();
        cyc++;
        done = obs_last && obs_xfer;
        if (cyc == 9)  ser_ready = 1'b0;
        if (cyc == 13) ser_ready = 1'b1;
      end
      if (!done) check("stall timeout", 32'd0, 32'd1);
    end
    check("stall cycles", cyc, 36);
    check("stall msb stream", cap_m, 32'h1234_5678);
    check("stall lsb stream", cap_l, 32'h1E6A_2C48);
    step();

    // Reset mid-word at bit 15, then a fresh word from its first bit.
    send_word(32'hCAFE_F00D);
    for (int i = 0; i < 14; i++) step();
    check("pre-reset valid", {31'd0, ser_valid_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    q_msb.delete();
    q_lsb.delete();
    q_idx.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    cap_m = '0;
    cap_l = '0;
    send_word(32'h0F0F_3C3C);
    step();
    check("post-reset first", {31'd0, obs_first}, 32'd1);
    run_to_last(cyc);
    check("post-reset stream", cap_m, 32'h0F0F_3C3C);
    check("post-reset cycles", cyc, W - 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = $urandom;
      step();
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    for (int i = 0; i < 2 * W + 4; i++) step();
    check("drained", {31'd0, ser_valid_m}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-in, serial-out transmitter for 32-bit words held in the datapath's 32-bit registers. Accepts one word per valid/ready handshake on its parallel side. Emits the word one bit per clock on a serial stream with its own valid/ready handshake. ser_first and ser_last mark the frame boundaries. Sits between a register bank and any 1-bit link or serial consumer.

Parameters:
WIDTH, 32, word width in bits; legal range WIDTH >= 2
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_data holds a word to transmit
in_ready  output  1  serializer accepts in_data this cycle
in_data  input  WIDTH  parallel word
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is a valid bit
ser_ready  input  1  downstream consumes ser_out this cycle
ser_first  output  1  ser_out is the first bit of a word
ser_last  output  1  ser_out is the last bit of a word
busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, bit counter 0. Outputs: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, in_ready=1.
- States: IDLE, SHIFT.
- Handshake terms:
  - accept = in_valid & in_ready
  - xfer = ser_valid & ser_ready
- in_ready = (state==IDLE) | (xfer & ser_last). This is a combinational path from ser_ready to in_ready, and it is intentional.
- IDLE, accept: shreg <= in_data, cnt <= 0, state -> SHIFT.
- SHIFT:
  - ser_valid = 1.
  - ser_out = shreg[WIDTH-1] when MSB_FIRST, else shreg[0].
- SHIFT, xfer, cnt < WIDTH-1: shift toward the output end, zero-fill the vacated bit, cnt <= cnt+1.
- SHIFT, xfer, cnt == WIDTH-1, with accept: reload shreg <= in_data, cnt <= 0, stay in SHIFT. Back-to-back words leave no idle bubble.
- SHIFT, xfer, cnt == WIDTH-1, no accept: state -> IDLE, ser_valid -> 0.
- SHIFT, ser_ready=0: shreg, cnt, ser_out and state all hold. ser_valid stays 1 and never drops mid-word.
- Frame markers and busy:
  - ser_first = ser_valid & (cnt==0)
  - ser_last = ser_valid & (cnt==WIDTH-1)
  - busy = (state==SHIFT)
- in_data is sampled only on accept; changes at any other time have no effect.
- Latency: word accepted at edge N, first bit valid in cycle N+1.
- Throughput: 1 word per WIDTH cycles with ser_ready held high.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and never wraps silently.
- in_valid while busy and not on the last-bit transfer: in_ready=0, and the upstream holds its word.
- Reset mid-word: the word is discarded immediately and outputs return to reset values. No partial frame resumes after release.
- No X on outputs after reset, regardless of in_data.

Decomposition:
- Shared header/package holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
  - default WIDTH=32 constant, shared with the register bank
- One natural sub-module: bit_counter.
  - Parameter: MAX.
  - Ports: clk, rst_n, clr, en, count, at_max.
  - Counts 0..MAX on en; clr has priority over en.
  - Instantiated with MAX=WIDTH-1; supplies cnt and the ser_last term.
- Shift register and FSM stay in the top module.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, release, in_valid=0 for 5 cycles -> ser_valid=0, busy=0, in_ready=1, ser_out=0 throughout.
2. Single word, MSB_FIRST=1, ser_ready=1: in_data=32'hA5A5_0F0F -> starting the cycle after accept, ser_out serial stream 1010_0101_1010_0101_0000_1111_0000_1111. ser_first only on the 1st bit, ser_last only on the 32nd, then ser_valid=0.
3. Back-to-back: 32'hFFFF_FFFF then 32'h0000_0001 with in_valid held -> 64 consecutive valid bits, no gap. in_ready high only in the ser_last cycle. ser_first on bits 1 and 33.
4. Backpressure: ser_ready=0 for 4 cycles at bit 10 of 32'h1234_5678 -> ser_out and ser_valid hold their values. The stream resumes with no bit lost or duplicated; total 36 cycles to last bit.
5. LSB first (MSB_FIRST=0): in_data=32'h0000_0003 -> first two bits 1,1, remaining 30 bits 0.
6. Reset mid-word: assert rst_n at bit 15 -> outputs go to reset values asynchronously. A new word accepted after release transmits from its first bit with ser_first=1.
